// File: rtl/dac_spi_pkg.sv
// -----------------------------------------------------------------------------
// dac_spi_pkg
// Shared definitions for the DAC/ADC SPI master:
//   state_e  - frame sequencer states (also exported on the debug state port)
//   frame_w  - total serial frame width from the three field widths
//   cs_w     - width of the chip-select index, at least one bit
//   cnt_w    - width of a counter that runs 0..n-1, at least one bit
//   max3     - largest of three integers (timing counter sizing)
// -----------------------------------------------------------------------------
package dac_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SHIFT = 3'd2,
      TRAIL = 3'd3,
      GAP   = 3'd4
   } state_e;

   function automatic int frame_w(input int comm_w, input int addr_w, input int data_w);
      return comm_w + addr_w + data_w;
   endfunction

   function automatic int cs_w(input int ncs);
      return (ncs > 1) ? $clog2(ncs) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dac_spi_master_bitclk.sv
// -----------------------------------------------------------------------------
// dac_spi_bitclk
// Bit timing generator for the SHIFT phase. A HALF_DIV phase counter splits
// each bit into two half-periods and produces the registered SCLK level.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   i_en         - current cycle is a SHIFT cycle (counter runs)
//   i_run_nxt    - next cycle is a SHIFT cycle (SCLK leaves idle level)
//   o_half_tick  - last cycle of a half-bit; the following edge ends the half
//   o_bit_end    - last cycle of a bit; the following edge is a bit boundary
//   o_sclk       - registered serial clock level
// -----------------------------------------------------------------------------
module dac_spi_bitclk
   import dac_spi_pkg::*;
#(
   parameter int HALF_DIV = 16,
   parameter bit CPOL     = 1'b1,
   parameter bit CPHA     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_run_nxt,
   output logic o_half_tick,
   output logic o_bit_end,
   output logic o_sclk
);

   localparam int              PH_W    = cnt_w(HALF_DIV);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);

   logic [PH_W-1:0] r_phase;
   logic            r_half;   // 0: first half of the bit, 1: second half
   logic            r_sclk;
   logic            w_half_nxt;

   // SCLK level for a given half of the bit.
   function automatic logic sclk_level(input logic second_half);
      if (CPHA) return second_half ? CPOL : ~CPOL;
      else      return second_half ? ~CPOL : CPOL;
   endfunction

   assign o_half_tick = i_en && (r_phase == PH_LAST);
   assign o_bit_end   = o_half_tick && r_half;

   // Every bit starts in its first half, including the first bit of a frame.
   assign w_half_nxt  = !i_en ? 1'b0 : (o_half_tick ? ~r_half : r_half);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase <= '0;
         r_half  <= 1'b0;
         r_sclk  <= CPOL;
      end else begin
         if (!i_en || o_half_tick) r_phase <= '0;
         else                      r_phase <= r_phase + PH_W'(1);
         r_half <= w_half_nxt;
         r_sclk <= i_run_nxt ? sclk_level(w_half_nxt) : CPOL;
      end
   end

   assign o_sclk = r_sclk;

endmodule

// File: rtl/dac_spi_master.sv
// -----------------------------------------------------------------------------
// dac_spi_master
// Serialises {comm,addr,data} command words MSB-first to one of NCS DAC/ADC
// chips, each with its own active-low sync line, and captures MISO into
// rd_data. Frame sequence: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_comm/cmd_addr/cmd_data    - frame fields, latched on accept
//   cmd_cs                        - target sync line index (>= NCS: no line)
//   spi_sclk/spi_sync_n/spi_data  - serial clock, per-chip sync, MOSI
//   spi_miso                      - readback data
//   busy                          - frame in progress (accept to IDLE)
//   done/err/rd_valid             - one-cycle pulses in the first GAP cycle
//   rd_data                       - MISO bits of the last frame, first in MSB
//   dbg_state                     - current sequencer state
//
// Handshake: a command is accepted on a clock edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE (never in a reset cycle),
// drops in the cycle after the accept and the fields are latched at that edge;
// later changes on cmd_* do not affect the frame. cmd_valid while cmd_ready is
// 0 is ignored.
//
// All outputs are registered: their next value is decoded from the
// next-state/next-counter signals and captured at the same edge as the state.
// -----------------------------------------------------------------------------
module dac_spi_master
   import dac_spi_pkg::*;
#(
   parameter int COMM_W    = 4,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 16,
   parameter int HALF_DIV  = 16,
   parameter bit CPOL      = 1'b1,
   parameter bit CPHA      = 1'b1,
   parameter int NCS       = 2,
   parameter int LEAD_CYC  = 16,
   parameter int TRAIL_CYC = 16,
   parameter int GAP_CYC   = 32
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         cmd_valid,
   output logic                                         cmd_ready,
   input  logic [COMM_W-1:0]                            cmd_comm,
   input  logic [ADDR_W-1:0]                            cmd_addr,
   input  logic [DATA_W-1:0]                            cmd_data,
   input  logic [cs_w(NCS)-1:0]                         cmd_cs,
   output logic                                         spi_sclk,
   output logic [NCS-1:0]                               spi_sync_n,
   output logic                                         spi_data,
   input  logic                                         spi_miso,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         err,
   output logic [frame_w(COMM_W, ADDR_W, DATA_W)-1:0]   rd_data,
   output logic                                         rd_valid,
   output state_e                                       dbg_state
);

   localparam int FRAME_W = frame_w(COMM_W, ADDR_W, DATA_W);
   localparam int CS_W    = cs_w(NCS);
   localparam int TCNT_W  = cnt_w(max3(LEAD_CYC, TRAIL_CYC, GAP_CYC));
   localparam int BCNT_W  = $clog2(FRAME_W + 1);

   localparam logic [TCNT_W-1:0] LEAD_LAST  = TCNT_W'(LEAD_CYC - 1);
   localparam logic [TCNT_W-1:0] TRAIL_LAST = TCNT_W'(TRAIL_CYC - 1);
   localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(GAP_CYC - 1);
   localparam logic [BCNT_W-1:0] BIT_LAST   = BCNT_W'(FRAME_W - 1);

   // Sequencer state and counters
   state_e               r_state,  w_state_nxt;
   logic [TCNT_W-1:0]    r_tcnt,   w_tcnt_nxt;
   logic [BCNT_W-1:0]    r_bcnt,   w_bcnt_nxt;
   logic [FRAME_W-1:0]   r_tx,     w_tx_nxt;
   logic [CS_W-1:0]      r_cs,     w_cs_nxt;
   logic                 w_accept;
   logic                 w_frame_end;

   // Output registers and their decode
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic                 r_rd_valid;
   logic                 r_data;
   logic [NCS-1:0]       r_sync_n;
   logic [NCS-1:0]       w_sync_nxt;
   logic                 w_frame_act;
   logic                 w_cs_ok;
   logic [FRAME_W-1:0]   r_rx;
   logic [FRAME_W-1:0]   r_rd_data;

   // Bit clock
   logic                 w_half_tick;
   logic                 w_bit_end;
   logic                 w_mid;
   logic                 w_sclk;

   dac_spi_bitclk #(
      .HALF_DIV (HALF_DIV),
      .CPOL     (CPOL),
      .CPHA     (CPHA)
   ) u_bitclk (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (r_state == SHIFT),
      .i_run_nxt   (w_state_nxt == SHIFT),
      .o_half_tick (w_half_tick),
      .o_bit_end   (w_bit_end),
      .o_sclk      (w_sclk)
   );

   // A half-tick that is not a bit end closes the first half: the following
   // edge is the mid-bit SCLK transition, where MISO is sampled.
   assign w_mid = w_half_tick && !w_bit_end;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_bcnt_nxt  = r_bcnt;
      w_tx_nxt    = r_tx;
      w_cs_nxt    = r_cs;
      w_accept    = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid && r_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = LEAD;
               w_tcnt_nxt  = '0;
               w_bcnt_nxt  = '0;
               w_tx_nxt    = {cmd_comm, cmd_addr, cmd_data};
               w_cs_nxt    = cmd_cs;
            end
         end
         LEAD: begin
            if (r_tcnt == LEAD_LAST) begin
               w_state_nxt = SHIFT;
               w_tcnt_nxt  = '0;
            end else begin
               w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
            end
         end
         SHIFT: begin
            if (w_bit_end) begin
               if (r_bcnt == BIT_LAST) begin
                  // No shift here so MOSI holds the last bit through TRAIL.
                  w_state_nxt = TRAIL;
                  w_tcnt_nxt  = '0;
               end else begin
                  w_bcnt_nxt  = r_bcnt + BCNT_W'(1);
                  w_tx_nxt    = {r_tx[FRAME_W-2:0], 1'b0};
               end
            end
         end
         TRAIL: begin
            if (r_tcnt == TRAIL_LAST) begin
               w_state_nxt = GAP;
               w_tcnt_nxt  = '0;
               w_frame_end = 1'b1;
            end else begin
               w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
            end
         end
         GAP: begin
            if (r_tcnt == GAP_LAST) begin
               w_state_nxt = IDLE;
               w_tcnt_nxt  = '0;
            end else begin
               w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_tx    <= '0;
         r_cs    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_tx    <= w_tx_nxt;
         r_cs    <= w_cs_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------------
   assign w_frame_act = (w_state_nxt == LEAD) || (w_state_nxt == SHIFT) ||
                        (w_state_nxt == TRAIL);

   // An out-of-range index matches no line, so all syncs stay high.
   always_comb begin
      w_sync_nxt = '1;
      w_cs_ok    = 1'b0;
      for (int i = 0; i < NCS; i++) begin
         if (r_cs == CS_W'(i)) w_cs_ok = 1'b1;
         if (w_frame_act && (w_cs_nxt == CS_W'(i))) w_sync_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_data     <= 1'b0;
         r_sync_n   <= '1;
         r_rx       <= '0;
         r_rd_data  <= '0;
      end else begin
         r_ready    <= (w_state_nxt == IDLE);
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_frame_end;
         r_err      <= w_frame_end && !w_cs_ok;
         r_rd_valid <= w_frame_end;
         r_data     <= w_frame_act ? w_tx_nxt[FRAME_W-1] : 1'b0;
         r_sync_n   <= w_sync_nxt;
         if (w_accept)   r_rx <= '0;
         else if (w_mid) r_rx <= {r_rx[FRAME_W-2:0], spi_miso};
         if (w_frame_end) r_rd_data <= r_rx;
      end
   end

   assign cmd_ready  = r_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign spi_data   = r_data;
   assign spi_sync_n = r_sync_n;
   assign spi_sclk   = w_sclk;
   assign dbg_state  = r_state;

endmodule
